// File: rtl/note_sequencer_synth.sv
// Playback engine: scans the note memory at a fixed tempo and streams a
// square-wave tone for each slot into the codec through a ready/write handshake.
module note_sequencer_synth #(
    parameter int          NUM_SLOTS        = 40,
    parameter int          SAMPLES_PER_STEP = 12000,
    parameter logic [23:0] AMPLITUDE        = 24'h100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic        stop,
    input  logic        loop,
    output logic [5:0]  slot_addr,
    input  logic [5:0]  slot_note,
    input  logic        write_ready,
    output logic        write,
    output logic [23:0] write_data,
    output logic        playing,
    output logic [5:0]  cur_slot
);

    localparam int             CNT_W       = $clog2(SAMPLES_PER_STEP + 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLES_PER_STEP - 1);
    localparam logic [5:0]     SLOT_LAST   = 6'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PLAY  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       slot_q, slot_d;
    logic [5:0]       note_q, note_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [8:0]       phase_cnt_q, phase_cnt_d;
    logic             phase_hi_q, phase_hi_d;
    logic             write_q, write_d;
    logic [23:0]      write_data_q, write_data_d;

    logic [8:0]       hp_s;
    logic             rest_s;
    logic [23:0]      sample_s;

    // Half-period in samples at 48 kHz for codes 1..36 (C3..B5); 0 means rest.
    function automatic logic [8:0] half_period(input logic [5:0] code);
        logic [8:0] hp;
        case (code)
            6'd1:  hp = 9'd183;
            6'd2:  hp = 9'd173;
            6'd3:  hp = 9'd163;
            6'd4:  hp = 9'd154;
            6'd5:  hp = 9'd146;
            6'd6:  hp = 9'd137;
            6'd7:  hp = 9'd130;
            6'd8:  hp = 9'd122;
            6'd9:  hp = 9'd116;
            6'd10: hp = 9'd109;
            6'd11: hp = 9'd103;
            6'd12: hp = 9'd97;
            6'd13: hp = 9'd92;
            6'd14: hp = 9'd87;
            6'd15: hp = 9'd82;
            6'd16: hp = 9'd77;
            6'd17: hp = 9'd73;
            6'd18: hp = 9'd69;
            6'd19: hp = 9'd65;
            6'd20: hp = 9'd61;
            6'd21: hp = 9'd58;
            6'd22: hp = 9'd55;
            6'd23: hp = 9'd51;
            6'd24: hp = 9'd49;
            6'd25: hp = 9'd46;
            6'd26: hp = 9'd43;
            6'd27: hp = 9'd41;
            6'd28: hp = 9'd39;
            6'd29: hp = 9'd36;
            6'd30: hp = 9'd34;
            6'd31: hp = 9'd32;
            6'd32: hp = 9'd31;
            6'd33: hp = 9'd29;
            6'd34: hp = 9'd27;
            6'd35: hp = 9'd26;
            6'd36: hp = 9'd24;
            default: hp = 9'd0;
        endcase
        return hp;
    endfunction

    // Sample value and rest detection for the latched note.
    always_comb begin
        hp_s   = half_period(note_q);
        rest_s = (hp_s == 9'd0);
        if (rest_s) begin
            sample_s = 24'd0;
        end else if (phase_hi_q) begin
            sample_s = AMPLITUDE;
        end else begin
            sample_s = (~AMPLITUDE) + 24'd1;
        end
    end

    // Next-state logic: sequencing, handshake and per-sample counters.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        note_d       = note_q;
        sample_cnt_d = sample_cnt_q;
        phase_cnt_d  = phase_cnt_q;
        phase_hi_d   = phase_hi_q;
        write_d      = 1'b0;
        write_data_d = write_data_q;

        case (state_q)
            S_IDLE: begin
                slot_d       = 6'd0;
                sample_cnt_d = '0;
                phase_cnt_d  = 9'd0;
                write_data_d = 24'd0;
                if (play) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                note_d       = slot_note;
                sample_cnt_d = '0;
                phase_cnt_d  = 9'd0;
                phase_hi_d   = 1'b1;
                state_d      = S_PLAY;
            end
            S_PLAY: begin
                if (write_q) begin
                    // The sample just strobed has been accepted: account for it.
                    if (rest_s) begin
                        phase_cnt_d = phase_cnt_q;
                    end else if (phase_cnt_q == (hp_s - 9'd1)) begin
                        phase_cnt_d = 9'd0;
                        phase_hi_d  = ~phase_hi_q;
                    end else begin
                        phase_cnt_d = phase_cnt_q + 9'd1;
                    end
                    if (sample_cnt_q == SAMPLE_LAST) begin
                        sample_cnt_d = '0;
                        if (slot_q != SLOT_LAST) begin
                            slot_d  = slot_q + 6'd1;
                            state_d = S_FETCH;
                        end else if (loop) begin
                            slot_d  = 6'd0;
                            state_d = S_FETCH;
                        end else begin
                            slot_d       = 6'd0;
                            state_d      = S_IDLE;
                            write_data_d = 24'd0;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    end
                end else if (write_ready) begin
                    write_d      = 1'b1;
                    write_data_d = sample_s;
                end else begin
                    write_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stop) begin
            state_d      = S_IDLE;
            slot_d       = 6'd0;
            sample_cnt_d = '0;
            phase_cnt_d  = 9'd0;
            phase_hi_d   = 1'b0;
            write_d      = 1'b0;
            write_data_d = 24'd0;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            slot_q       <= 6'd0;
            note_q       <= 6'd0;
            sample_cnt_q <= '0;
            phase_cnt_q  <= 9'd0;
            phase_hi_q   <= 1'b0;
            write_q      <= 1'b0;
            write_data_q <= 24'd0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            note_q       <= note_d;
            sample_cnt_q <= sample_cnt_d;
            phase_cnt_q  <= phase_cnt_d;
            phase_hi_q   <= phase_hi_d;
            write_q      <= write_d;
            write_data_q <= write_data_d;
        end
    end

    assign slot_addr  = slot_q;
    assign cur_slot   = slot_q;
    assign write      = write_q;
    assign write_data = write_data_q;
    assign playing    = (state_q == S_FETCH) || (state_q == S_PLAY);

endmodule

// File: tb/tb_note_sequencer_synth.sv
// Directed bench for note_sequencer_synth: waveform, timing, handshake,
// stop/reset and end-of-pass behaviour with hand-computed expectations.
module tb_note_sequencer_synth;

    localparam int          SPS = 120;
    localparam int          NS  = 40;
    localparam logic [23:0] AMP = 24'h100000;
    localparam logic [23:0] NEG = 24'hF00000;

    logic        clk = 1'b0;
    logic        reset, play, stop, loop, write_ready;
    logic [5:0]  slot_addr, slot_note, cur_slot;
    logic        write, playing;
    logic [23:0] write_data;
    logic [5:0]  mem [64];

    int n_checks = 0;
    int n_pass   = 0;
    int b2b_err = 0, noready_err = 0;
    logic prev_wr = 1'b0, prev_write = 1'b0;

    always #5 clk = ~clk;

    assign slot_note = mem[slot_addr];

    note_sequencer_synth #(.NUM_SLOTS(NS), .SAMPLES_PER_STEP(SPS), .AMPLITUDE(AMP)) u_dut (
        .clk(clk), .reset(reset), .play(play), .stop(stop), .loop(loop),
        .slot_addr(slot_addr), .slot_note(slot_note), .write_ready(write_ready),
        .write(write), .write_data(write_data), .playing(playing), .cur_slot(cur_slot)
    );

    // Handshake monitor: no back-to-back strobes, no strobe without prior ready.
    always @(negedge clk) begin
        if (write && prev_write) b2b_err++;
        if (write && !prev_wr) noready_err++;
        prev_wr    = write_ready;
        prev_write = write;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_write(input int limit, output logic [23:0] d, output logic [5:0] s, output bit ok);
        int i;
        ok = 1'b0;
        i  = 0;
        while (!ok && i < limit) begin
            tick();
            if (write) begin
                d  = write_data;
                s  = cur_slot;
                ok = 1'b1;
            end
            i++;
        end
    endtask

    // Collect samples k0..SPS-1 of one step; hp=0 marks a rest slot.
    task automatic run_step(input logic [5:0] slot, input int hp, input int k0, output int errs);
        logic [23:0] d, e;
        logic [5:0]  s;
        bit          ok;
        errs = 0;
        for (int k = k0; k < SPS; k++) begin
            wait_write(20, d, s, ok);
            if (hp == 0) e = 24'd0;
            else e = (((k / hp) % 2) == 0) ? AMP : NEG;
            if (!ok || d !== e || s !== slot) errs++;
        end
    endtask

    initial begin
        int          errs, cnt, pcnt, dnz, bad, last;
        bit          ok, seen39;
        logic [23:0] d;
        logic [5:0]  s;

        for (int i = 0; i < 64; i++) mem[i] = 6'd1;
        mem[0] = 6'd22; mem[1] = 6'd0; mem[2] = 6'd50; mem[3] = 6'd10;
        reset = 1'b1; play = 1'b0; stop = 1'b0; loop = 1'b0; write_ready = 1'b0;
        repeat (3) tick();
        check_val("rst_write", write, 1'b0);
        check_val("rst_playing", playing, 1'b0);
        check_val("rst_slot", slot_addr, 6'd0);
        check_val("rst_data", write_data, 24'd0);
        reset = 1'b0;

        // Idle with ready high: nothing happens.
        write_ready = 1'b1;
        cnt = 0; pcnt = 0; dnz = 0;
        repeat (100) begin
            tick();
            if (write) cnt++;
            if (playing) pcnt++;
            if (write_data != 24'd0) dnz++;
        end
        check_val("idle_writes", cnt, 0);
        check_val("idle_playing", pcnt, 0);
        check_val("idle_data", dnz, 0);

        // Start latency: FETCH at 1, PLAY at 2, first strobe at 3.
        play = 1'b1; tick(); play = 1'b0;
        check_val("lat_c1_playing", playing, 1'b1);
        check_val("lat_c1_write", write, 1'b0);
        tick();
        check_val("lat_c2_write", write, 1'b0);
        tick();
        check_val("lat_c3_write", write, 1'b1);
        check_val("lat_c3_data", write_data, AMP);

        run_step(6'd0, 55, 1, errs);
        check_val("slot0_a4_wave", errs, 0);
        tick();
        check_val("slot0_advance", slot_addr, 6'd1);
        run_step(6'd1, 0, 0, errs);
        check_val("slot1_rest0", errs, 0);
        run_step(6'd2, 0, 0, errs);
        check_val("slot2_rest50", errs, 0);
        run_step(6'd3, 109, 0, errs);
        check_val("slot3_a3_wave", errs, 0);
        tick();
        check_val("slot3_advance", slot_addr, 6'd4);

        // Ready pulsed 1 high / 3 low: exactly one strobe per pulse.
        write_ready = 1'b0;
        repeat (3) tick();
        bad = 0;
        for (int w = 0; w < SPS; w++) begin
            cnt = 0;
            write_ready = 1'b1;
            tick();
            if (write) begin
                cnt++;
                if (write_data !== AMP || cur_slot !== 6'd4) bad++;
            end
            write_ready = 1'b0;
            repeat (3) begin
                tick();
                if (write) cnt++;
            end
            if (cnt != 1) bad++;
        end
        check_val("throttle_windows", bad, 0);
        check_val("throttle_advance", slot_addr, 6'd5);

        // Stop and play together while playing slot 5.
        write_ready = 1'b1;
        for (int i = 0; i < 10; i++) wait_write(20, d, s, ok);
        check_val("slot5_reached", s, 6'd5);
        tick();
        stop = 1'b1; play = 1'b1; tick(); stop = 1'b0; play = 1'b0;
        check_val("stop_write", write, 1'b0);
        check_val("stop_slot", slot_addr, 6'd0);
        check_val("stop_playing", playing, 1'b0);
        check_val("stop_data", write_data, 24'd0);
        cnt = 0;
        repeat (10) begin
            tick();
            if (write || playing) cnt++;
        end
        check_val("stop_stays_idle", cnt, 0);

        // Reset mid-step with a strobe pending.
        play = 1'b1; tick(); play = 1'b0;
        for (int i = 0; i < 5; i++) wait_write(20, d, s, ok);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check_val("mrst_write", write, 1'b0);
        check_val("mrst_playing", playing, 1'b0);
        check_val("mrst_slot", slot_addr, 6'd0);
        check_val("mrst_data", write_data, 24'd0);

        // Restart, then a full non-looping pass.
        play = 1'b1; tick(); play = 1'b0;
        tick(); tick();
        check_val("restart_write", write, 1'b1);
        check_val("restart_data", write_data, AMP);
        check_val("restart_slot", cur_slot, 6'd0);
        cnt = 1; last = 0; pcnt = 0;
        while (playing && pcnt < 30000) begin
            tick();
            if (write) begin
                cnt++;
                last = int'(cur_slot);
            end
            pcnt++;
        end
        check_val("pass_timeout", (pcnt < 30000) ? 1 : 0, 1);
        check_val("pass_writes", cnt, NS * SPS);
        check_val("pass_last_slot", last, NS - 1);
        check_val("pass_end_slot", slot_addr, 6'd0);
        check_val("pass_end_playing", playing, 1'b0);
        check_val("pass_end_data", write_data, 24'd0);

        // Looping pass: slot 39 wraps to 0 and playback continues.
        loop = 1'b1;
        play = 1'b1; tick(); play = 1'b0;
        cnt = 0; seen39 = 1'b0; pcnt = 0;
        while (!(seen39 && slot_addr == 6'd0) && pcnt < 12000) begin
            if (write) begin
                cnt++;
                if (cur_slot == 6'd39) seen39 = 1'b1;
            end
            tick();
            pcnt++;
        end
        check_val("loop_timeout", (pcnt < 12000) ? 1 : 0, 1);
        check_val("loop_writes", cnt, NS * SPS);
        check_val("loop_playing", playing, 1'b1);
        wait_write(20, d, s, ok);
        check_val("loop_resume_ok", ok, 1'b1);
        check_val("loop_resume_data", d, AMP);
        check_val("loop_resume_slot", s, 6'd0);
        stop = 1'b1; tick(); stop = 1'b0;
        tick();

        check_val("mon_back_to_back", b2b_err, 0);
        check_val("mon_no_ready", noready_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/note_sequencer_synth.md
Name: note_sequencer_synth

Overview:
Playback engine between the composition interface and the audio codec. Steps through the 40-slot note memory at a fixed tempo and synthesises a square-wave tone for each slot's note. Pushes 24-bit samples into the codec through its write_ready/write handshake; the same word is driven to both channels at top level. Slot index is exported so the display can highlight the note currently playing.

Parameters:
NUM_SLOTS, 40, number of note slots scanned per pass (slot 0 .. NUM_SLOTS-1)
SAMPLES_PER_STEP, 12000, codec samples accepted per slot (0.25 s at 48 kHz); benches override to small values
AMPLITUDE, 24'h100000, square-wave peak magnitude (positive; negative half is two's complement)

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-high reset
play  input  1  single-cycle start pulse
stop  input  1  single-cycle stop pulse
loop  input  1  level; 1 = wrap to slot 0 after last slot, 0 = stop after last slot
slot_addr  output  6  slot index presented to note memory
slot_note  input  6  note code at slot_addr (combinational read, valid same cycle)
write_ready  input  1  codec FIFO can accept a sample
write  output  1  one-cycle sample write strobe to codec
write_data  output  24  signed sample, valid while write=1
playing  output  1  high in FETCH or PLAY
cur_slot  output  6  slot currently sounding (equals slot_addr)

Behaviour:
- Reset: state IDLE, slot_addr=0, cur_slot=0, write=0, write_data=0, playing=0, all counters 0.
- Note code: 0 = rest; 1..36 = C3..B5 chromatic (code 1 = C3, code 22 = A4 440 Hz); 37..63 treated as rest.
- Half-period: HP(n) = round-half-up(24000 / f(n)), f(n) = 130.8128*2^((n-1)/12). Internal 36-entry constant ROM, 9-bit. Examples: code 22 -> 55, code 10 -> 109, code 1 -> 183.
- IDLE: write=0, playing=0. play=1 -> FETCH with slot_addr=0.
- FETCH (one cycle): latch slot_note into note register; clear sample and phase counters; phase level=high; go PLAY.
- PLAY, handshake rules:
  - If write_ready=1 and write=0 in cycle t, then write=1 in cycle t+1 for exactly one cycle, with write_data registered alongside.
  - Never two consecutive write cycles. No write while write_ready=0.
- Sample value: rest -> 24'd0; phase high -> +AMPLITUDE; phase low -> -AMPLITUDE.
- Per accepted sample (the write=1 cycle):
  - Phase counter increments. When it reaches HP-1 it wraps to 0 and phase level toggles; the toggle applies to the next sample.
  - Sample counter increments. When it reaches SAMPLES_PER_STEP-1, advance the slot:
    - slot < NUM_SLOTS-1: slot+1, go FETCH.
    - last slot, loop=1: slot 0, go FETCH.
    - last slot, loop=0: slot 0, go IDLE.
- stop=1 in any state -> IDLE next cycle: write=0, write_data=0, slot_addr=0. Stop wins over simultaneous play. play while already playing is ignored.
- Reset asserted mid-sample or mid-step: all state returns to reset values next edge; no partial strobe.
- Latency: play at cycle 0 -> FETCH at 1 -> PLAY at 2 -> earliest write at cycle 3 (write_ready held high).
- Note memory edits during playback take effect only at the next FETCH of that slot.

Test Plan:
- Reset then idle, write_ready=1 for 100 cycles -> write never asserted, playing=0, write_data=0.
- SAMPLES_PER_STEP=120, slot 0 = code 22, write_ready=1, pulse play -> first write at cycle 3 with data 24'h100000; 55 samples of +AMP, 55 of 24'hF00000, then 10 of +AMP; slot_addr becomes 1 after sample 120.
- Slot holds code 0 and another holds code 50 -> every sample is 0 for both slots; step timing unchanged.
- write_ready toggled 1-cycle high / 3-cycles low -> exactly one write per high pulse; no back-to-back writes; sample count and slot advance still exact.
- SAMPLES_PER_STEP=4, NUM_SLOTS=40, loop=0 -> 160 writes, then IDLE, playing=0, slot_addr=0. Same with loop=1 -> slot 39 wraps to 0 and playback continues.
- Pulse stop and play in the same cycle during PLAY at slot 5 -> IDLE next cycle, write=0, slot_addr=0. Reset mid-step gives the same state; a subsequent play restarts at slot 0.
